// File: rtl/dlsc_pxdma_ackgen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dlsc_pxdma_ackgen_if                                            |
// | Purpose  : row_done / row_ack handshake bundle between pxdma producers,    |
// |            the ack generator and a consumer pxdma.                         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface dlsc_pxdma_ackgen_if #(
    parameter int SRCS  = 1,
    parameter int YBITS = 12
) ();

    logic [SRCS-1:0]  src_row_done;
    logic             dst_row_ack;
    logic             frame_start;
    logic             frame_done;
    logic [YBITS-1:0] row;

    // Producer/consumer side of the handshake.
    modport master (
        output src_row_done,
        input  dst_row_ack,
        input  frame_start,
        input  frame_done,
        input  row
    );

    // Ack generator side.
    modport slave (
        input  src_row_done,
        output dst_row_ack,
        output frame_start,
        output frame_done,
        output row
    );

endinterface
`default_nettype wire

// File: rtl/dlsc_pxdma_ackgen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dlsc_pxdma_ackgen                                               |
// | Purpose  : Releases one row_ack per row completed by every producer,       |
// |            tracks row/frame position and flags credit overflow.            |
// | Options  : DLSC_PXDMA_ACKGEN_WHOLE_FRAME_EN adds whole_frame gating.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dlsc_pxdma_ackgen #(
    parameter int SRCS  = 1,
    parameter int YBITS = 12
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             enable,
    input  wire logic [YBITS-1:0] vdisp,
    input  wire logic             double_buffer,
`ifdef DLSC_PXDMA_ACKGEN_WHOLE_FRAME_EN
    input  wire logic             whole_frame,
`endif
    output logic                  overflow,
    dlsc_pxdma_ackgen_if.slave    hs
);

    localparam int                 c_CNT_W   = YBITS + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [YBITS-1:0]   c_ROW_ONE = YBITS'(1);

    logic [c_CNT_W-1:0] r_cnt      [SRCS];
    logic [c_CNT_W-1:0] w_cnt_next [SRCS];
    logic [SRCS-1:0]    w_ovf;
    logic [c_CNT_W-1:0] w_limit;
    logic [c_CNT_W-1:0] w_frame_rows;
    logic               w_flush;
    logic               w_frame_hold;
    logic               w_ack_ok;
    logic               w_last_row;

    logic [YBITS-1:0]   r_row;
    logic               r_ack;
    logic               r_start;
    logic               r_done;
    logic               r_overflow;

    assign w_flush      = rst | ~enable;
    assign w_limit      = double_buffer ? {vdisp, 1'b0} : {1'b0, vdisp};
    assign w_frame_rows = {1'b0, vdisp};
    assign w_last_row   = (r_row == (vdisp - c_ROW_ONE));

`ifdef DLSC_PXDMA_ACKGEN_WHOLE_FRAME_EN
    assign w_frame_hold = whole_frame && (r_row == '0);
`else
    assign w_frame_hold = 1'b0;
`endif

    // Ack needs credit from every producer, and a full frame of it while held at row 0.
    always_comb begin
        w_ack_ok = 1'b1;
        for (int j = 0; j < SRCS; j++) begin
            if (r_cnt[j] == '0) begin
                w_ack_ok = 1'b0;
            end
            if (w_frame_hold && (r_cnt[j] < w_frame_rows)) begin
                w_ack_ok = 1'b0;
            end
        end
    end

    // A done that meets a same-cycle ack cancels out; a done beyond the limit is dropped.
    always_comb begin
        for (int j = 0; j < SRCS; j++) begin
            w_cnt_next[j] = r_cnt[j];
            w_ovf[j]      = 1'b0;
            if (hs.src_row_done[j] && !w_ack_ok) begin
                if (r_cnt[j] >= w_limit) begin
                    w_ovf[j] = 1'b1;
                end else begin
                    w_cnt_next[j] = r_cnt[j] + c_CNT_ONE;
                end
            end else if (!hs.src_row_done[j] && w_ack_ok) begin
                w_cnt_next[j] = r_cnt[j] - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < SRCS; j++) begin
            if (w_flush) begin
                r_cnt[j] <= '0;
            end else begin
                r_cnt[j] <= w_cnt_next[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_row      <= '0;
            r_ack      <= 1'b0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_ack   <= w_ack_ok;
            r_start <= w_ack_ok && (r_row == '0);
            r_done  <= w_ack_ok && w_last_row;
            if (w_ack_ok) begin
                r_row <= w_last_row ? '0 : (r_row + c_ROW_ONE);
            end
            if (|w_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign hs.dst_row_ack = r_ack;
    assign hs.frame_start = r_start;
    assign hs.frame_done  = r_done;
    assign hs.row         = r_row;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dlsc_pxdma_ackgen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dlsc_pxdma_ackgen                                            |
// | Purpose  : Directed self-checking bench; one SRCS=1 and one SRCS=2 DUT.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dlsc_pxdma_ackgen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en1 = 1'b0, en2 = 1'b0;
    logic        db1 = 1'b0, db2 = 1'b0;
    logic [11:0] vd1 = 12'd4, vd2 = 12'd4;
    logic        ovf1, ovf2;
`ifdef DLSC_PXDMA_ACKGEN_WHOLE_FRAME_EN
    logic        wf1 = 1'b0, wf2 = 1'b0;
`endif

    int tests  = 0;
    int failed = 0;
    int ack1 = 0, fs1 = 0, fd1 = 0;
    int ack2 = 0, fs2 = 0, fd2 = 0;
    logic last_fd2 = 1'b0;

    always #5 clk = ~clk;

    dlsc_pxdma_ackgen_if #(.SRCS(1), .YBITS(12)) if1 ();
    dlsc_pxdma_ackgen_if #(.SRCS(2), .YBITS(12)) if2 ();

    dlsc_pxdma_ackgen #(.SRCS(1), .YBITS(12)) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .enable        (en1),
        .vdisp         (vd1),
        .double_buffer (db1),
`ifdef DLSC_PXDMA_ACKGEN_WHOLE_FRAME_EN
        .whole_frame   (wf1),
`endif
        .overflow      (ovf1),
        .hs            (if1)
    );

    dlsc_pxdma_ackgen #(.SRCS(2), .YBITS(12)) u_dut2 (
        .clk           (clk),
        .rst           (rst),
        .enable        (en2),
        .vdisp         (vd2),
        .double_buffer (db2),
`ifdef DLSC_PXDMA_ACKGEN_WHOLE_FRAME_EN
        .whole_frame   (wf2),
`endif
        .overflow      (ovf2),
        .hs            (if2)
    );

    // Ack/frame pulse tallies, sampled mid-cycle.
    always @(negedge clk) begin
        if (if1.dst_row_ack) begin
            ack1 <= ack1 + 1;
            fs1  <= fs1 + int'(if1.frame_start);
            fd1  <= fd1 + int'(if1.frame_done);
        end
        if (if2.dst_row_ack) begin
            ack2     <= ack2 + 1;
            fs2      <= fs2 + int'(if2.frame_start);
            fd2      <= fd2 + int'(if2.frame_done);
            last_fd2 <= if2.frame_done;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic flush1(input logic [11:0] vd, input logic db);
        en1 = 1'b0; vd1 = vd; db1 = db;
        step();
        en1 = 1'b1;
    endtask

    task automatic flush2(input logic [11:0] vd, input logic db);
        en2 = 1'b0; vd2 = vd; db2 = db;
        step();
        en2 = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en1 = 1'b1; en2 = 1'b1;
        if1.src_row_done = 1'b1;
        if2.src_row_done = 2'b11;
        repeat (3) step();
        tests++; if (if1.dst_row_ack !== 1'b0) begin failed++; $display("FAIL reset_ack1: got %b want 0", if1.dst_row_ack); end
        tests++; if (if1.row !== 12'd0) begin failed++; $display("FAIL reset_row1: got %0d want 0", if1.row); end
        tests++; if (ovf1 !== 1'b0) begin failed++; $display("FAIL reset_ovf1: got %b want 0", ovf1); end
        tests++; if (if2.dst_row_ack !== 1'b0) begin failed++; $display("FAIL reset_ack2: got %b want 0", if2.dst_row_ack); end
        tests++; if (if2.frame_start !== 1'b0 || if2.frame_done !== 1'b0) begin failed++; $display("FAIL reset_frame2: got %b%b want 00", if2.frame_start, if2.frame_done); end
        rst = 1'b0;
        if1.src_row_done = 1'b0;
        if2.src_row_done = 2'b00;
        repeat (4) step();
        tests++; if (ack1 !== 0 || ack2 !== 0) begin failed++; $display("FAIL reset_discard: got %0d/%0d acks want 0/0", ack1, ack2); end
    endtask

    task automatic test_single_ack();
        flush1(12'd4, 1'b0);
        if1.src_row_done = 1'b1;
        step();
        if1.src_row_done = 1'b0;
        tests++; if (if1.dst_row_ack !== 1'b0) begin failed++; $display("FAIL single_early: got %b want 0", if1.dst_row_ack); end
        step();
        tests++; if (if1.dst_row_ack !== 1'b1) begin failed++; $display("FAIL single_ack: got %b want 1", if1.dst_row_ack); end
        tests++; if (if1.row !== 12'd1) begin failed++; $display("FAIL single_row: got %0d want 1", if1.row); end
        tests++; if (if1.frame_start !== 1'b1) begin failed++; $display("FAIL single_fs: got %b want 1", if1.frame_start); end
        tests++; if (if1.frame_done !== 1'b0) begin failed++; $display("FAIL single_fd: got %b want 0", if1.frame_done); end
        step();
        tests++; if (if1.dst_row_ack !== 1'b0) begin failed++; $display("FAIL single_once: got %b want 0", if1.dst_row_ack); end
    endtask

    task automatic test_two_sources();
        int a0, s0, f0;
        flush2(12'd4, 1'b0);
        a0 = ack2; s0 = fs2; f0 = fd2;
        repeat (4) begin if2.src_row_done = 2'b01; step(); end
        if2.src_row_done = 2'b00;
        repeat (3) step();
        tests++; if (ack2 - a0 !== 0) begin failed++; $display("FAIL two_wait: got %0d acks want 0", ack2 - a0); end
        if2.src_row_done = 2'b10; step();
        if2.src_row_done = 2'b00;
        repeat (3) step();
        tests++; if (ack2 - a0 !== 1) begin failed++; $display("FAIL two_first: got %0d acks want 1", ack2 - a0); end
        tests++; if (if2.row !== 12'd1) begin failed++; $display("FAIL two_row1: got %0d want 1", if2.row); end
        tests++; if (fs2 - s0 !== 1) begin failed++; $display("FAIL two_fs: got %0d want 1", fs2 - s0); end
        repeat (3) begin if2.src_row_done = 2'b10; step(); end
        if2.src_row_done = 2'b00;
        repeat (4) step();
        tests++; if (ack2 - a0 !== 4) begin failed++; $display("FAIL two_total: got %0d acks want 4", ack2 - a0); end
        tests++; if (fd2 - f0 !== 1 || last_fd2 !== 1'b1) begin failed++; $display("FAIL two_fd: got %0d/%b want 1/1", fd2 - f0, last_fd2); end
        tests++; if (if2.row !== 12'd0) begin failed++; $display("FAIL two_wrap: got %0d want 0", if2.row); end
        tests++; if (ovf2 !== 1'b0) begin failed++; $display("FAIL two_ovf: got %b want 0", ovf2); end
    endtask

    task automatic test_overflow();
        int a0, f0;
        flush2(12'd3, 1'b0);
        a0 = ack2; f0 = fd2;
        repeat (3) begin if2.src_row_done = 2'b01; step(); end
        tests++; if (ovf2 !== 1'b0) begin failed++; $display("FAIL ovf_at_limit: got %b want 0", ovf2); end
        if2.src_row_done = 2'b01; step();
        if2.src_row_done = 2'b00; step();
        tests++; if (ovf2 !== 1'b1) begin failed++; $display("FAIL ovf_set: got %b want 1", ovf2); end
        tests++; if (ack2 - a0 !== 0) begin failed++; $display("FAIL ovf_noack: got %0d want 0", ack2 - a0); end
        repeat (4) begin if2.src_row_done = 2'b10; step(); end
        if2.src_row_done = 2'b00;
        repeat (5) step();
        tests++; if (ack2 - a0 !== 3) begin failed++; $display("FAIL ovf_acks: got %0d want 3", ack2 - a0); end
        tests++; if (fd2 - f0 !== 1 || if2.row !== 12'd0) begin failed++; $display("FAIL ovf_frame: got fd %0d row %0d want 1/0", fd2 - f0, if2.row); end
        tests++; if (ovf2 !== 1'b1) begin failed++; $display("FAIL ovf_sticky: got %b want 1", ovf2); end
        en2 = 1'b0; step();
        tests++; if (ovf2 !== 1'b0) begin failed++; $display("FAIL ovf_clear: got %b want 0", ovf2); end
        en2 = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic exp;
        flush1(12'd8, 1'b0);
        if1.src_row_done = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 5) if1.src_row_done = 1'b0;
            exp = (i >= 2 && i <= 6);
            tests++; if (if1.dst_row_ack !== exp) begin failed++; $display("FAIL b2b_cycle%0d: got %b want %b", i, if1.dst_row_ack, exp); end
        end
        tests++; if (if1.row !== 12'd5) begin failed++; $display("FAIL b2b_row: got %0d want 5", if1.row); end
    endtask

    task automatic test_enable_drop();
        int a0, s0;
        flush2(12'd4, 1'b1);
        a0 = ack2;
        repeat (3) begin if2.src_row_done = 2'b01; step(); end
        repeat (2) begin if2.src_row_done = 2'b11; step(); end
        if2.src_row_done = 2'b00;
        repeat (4) step();
        tests++; if (ack2 - a0 !== 2 || if2.row !== 12'd2) begin failed++; $display("FAIL drop_setup: got %0d acks row %0d want 2/2", ack2 - a0, if2.row); end
        en2 = 1'b0; step();
        en2 = 1'b1;
        a0 = ack2; s0 = fs2;
        repeat (3) step();
        tests++; if (ack2 - a0 !== 0) begin failed++; $display("FAIL drop_noack: got %0d want 0", ack2 - a0); end
        tests++; if (if2.row !== 12'd0 || ovf2 !== 1'b0) begin failed++; $display("FAIL drop_clear: got row %0d ovf %b want 0/0", if2.row, ovf2); end
        if2.src_row_done = 2'b01; step();
        if2.src_row_done = 2'b00;
        repeat (3) step();
        tests++; if (ack2 - a0 !== 0) begin failed++; $display("FAIL drop_fresh: got %0d acks want 0", ack2 - a0); end
        if2.src_row_done = 2'b10; step();
        if2.src_row_done = 2'b00;
        repeat (4) step();
        tests++; if (ack2 - a0 !== 1) begin failed++; $display("FAIL drop_resume: got %0d acks want 1", ack2 - a0); end
        tests++; if (fs2 - s0 !== 1 || if2.row !== 12'd1) begin failed++; $display("FAIL drop_fs: got fs %0d row %0d want 1/1", fs2 - s0, if2.row); end
    endtask

`ifdef DLSC_PXDMA_ACKGEN_WHOLE_FRAME_EN
    task automatic test_whole_frame();
        int a0;
        logic exp;
        wf1 = 1'b1;
        flush1(12'd4, 1'b0);
        a0 = ack1;
        repeat (3) begin if1.src_row_done = 1'b1; step(); end
        if1.src_row_done = 1'b0;
        repeat (4) step();
        tests++; if (ack1 - a0 !== 0) begin failed++; $display("FAIL wf_hold: got %0d acks want 0", ack1 - a0); end
        if1.src_row_done = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if1.src_row_done = 1'b0;
            exp = (i >= 2 && i <= 5);
            tests++; if (if1.dst_row_ack !== exp) begin failed++; $display("FAIL wf_cycle%0d: got %b want %b", i, if1.dst_row_ack, exp); end
            if (i == 5) begin
                tests++; if (if1.frame_done !== 1'b1) begin failed++; $display("FAIL wf_fd: got %b want 1", if1.frame_done); end
            end
        end
        wf1 = 1'b0;
    endtask
`endif

    initial begin
        if1.src_row_done = 1'b0;
        if2.src_row_done = 2'b00;
        step();
        test_reset();
        test_single_ack();
        test_two_sources();
        test_overflow();
        test_back_to_back();
        test_enable_drop();
`ifdef DLSC_PXDMA_ACKGEN_WHOLE_FRAME_EN
        test_whole_frame();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
